// File: rtl/lpm_request_deser.sv
// lpm_request_deser: assembles host request words (header + payload) into one
// 144-bit pipe message {tag, word0..word3} and offers it on an enq handshake.
// Malformed requests (unknown tag or wrong length) are drained without output.
// Optional build macro: LPM_DESER_ERRCNT_EN adds a saturating err_count port.
module lpm_request_deser #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 16,
  parameter int PAYLOAD_WORDS = 4,
  parameter int NUM_TAGS      = 2
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic [DATA_WIDTH-1:0]                     in_data,
  input  logic                                      in_valid,
  output logic                                      in_rdy,
  output logic                                      pipe_enq__ENA,
  output logic [TAG_WIDTH+PAYLOAD_WORDS*DATA_WIDTH-1:0] pipe_enq_v,
  input  logic                                      pipe_enq__RDY,
  output logic                                      busy
`ifdef LPM_DESER_ERRCNT_EN
  ,
  output logic [15:0]                               err_count
`endif
);

  localparam int PAYLOAD_W = PAYLOAD_WORDS * DATA_WIDTH;
  localparam int LEN_W     = DATA_WIDTH - TAG_WIDTH;
  localparam int IDX_W     = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [IDX_W-1:0]     index_q;
  logic [IDX_W-1:0]     last_idx_q;
  logic [LEN_W-1:0]     remaining_q;

  logic [TAG_WIDTH-1:0] hdr_tag;
  logic [LEN_W-1:0]     hdr_len;
  logic                 xfer;
  logic                 hdr_ok;

  // Payload length each known method expects; unknown tags map to 0 (never legal).
  function automatic logic [LEN_W-1:0] required_len(input logic [TAG_WIDTH-1:0] t);
    if (t == TAG_WIDTH'(0))      return LEN_W'(1);
    else if (t == TAG_WIDTH'(1)) return LEN_W'(2);
    else                         return LEN_W'(0);
  endfunction

  assign hdr_tag = in_data[DATA_WIDTH-1 -: TAG_WIDTH];
  assign hdr_len = in_data[LEN_W-1:0];
  assign xfer    = in_valid && in_rdy;
  assign hdr_ok  = (hdr_tag < TAG_WIDTH'(NUM_TAGS)) && (hdr_len != '0) &&
                   (hdr_len == required_len(hdr_tag));

  assign in_rdy        = (state != HOLD);
  assign busy          = (state != IDLE);
  assign pipe_enq__ENA = (state == HOLD) && pipe_enq__RDY;
  assign pipe_enq_v    = {tag_q, payload_q};

  // Request framing FSM: decode header, collect payload, drain bad requests, hold message.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state       <= IDLE;
      tag_q       <= '0;
      payload_q   <= '0;
      index_q     <= '0;
      last_idx_q  <= '0;
      remaining_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (hdr_ok) begin
              tag_q      <= hdr_tag;
              payload_q  <= '0;
              index_q    <= '0;
              last_idx_q <= IDX_W'(hdr_len - LEN_W'(1));
              state      <= COLLECT;
            end else if (hdr_len != '0) begin
              remaining_q <= hdr_len;
              state       <= DRAIN;
            end
          end
        end
        COLLECT: begin
          if (xfer) begin
            payload_q[(PAYLOAD_WORDS-1-int'(index_q))*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (index_q == last_idx_q) state <= HOLD;
            else                       index_q <= index_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (remaining_q == LEN_W'(1)) state <= IDLE;
            else                          remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        HOLD: begin
          if (pipe_enq__RDY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LPM_DESER_ERRCNT_EN
  logic hdr_err;
  assign hdr_err = (state == IDLE) && xfer && !hdr_ok;

  // Count malformed headers once each, saturating so the count never wraps.
  always_ff @(posedge CLK) begin
    if (nRST)                              err_count <= '0;
    else if (hdr_err && (err_count != '1)) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lpm_request_deser.sv
// tb_lpm_request_deser: directed self-checking bench for lpm_request_deser.
// Build with LPM_DESER_ERRCNT_EN defined to also exercise err_count.
`timescale 1ns/1ps
module tb_lpm_request_deser;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_rdy;
  logic         pipe_enq__ENA;
  logic [143:0] pipe_enq_v;
  logic         pipe_enq__RDY = 1'b0;
  logic         busy;
`ifdef LPM_DESER_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ena_cnt  = 0;
  int exp_err  = 0;

  lpm_request_deser dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_rdy        (in_rdy),
    .pipe_enq__ENA (pipe_enq__ENA),
    .pipe_enq_v    (pipe_enq_v),
    .pipe_enq__RDY (pipe_enq__RDY),
    .busy          (busy)
`ifdef LPM_DESER_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  // Free-running clock, 10 ns period.
  always #5 CLK = ~CLK;

  // Count every accepted message transfer.
  always @(posedge CLK) begin
    if (pipe_enq__ENA) ena_cnt++;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one word for exactly one clock edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    idle_cycles(2);
    n_checks++; if (pipe_enq_v !== 144'd0) begin n_fail++; $display("[TB] FAIL reset_v: got %h expected 0", pipe_enq_v); end
    n_checks++; if (pipe_enq__ENA !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ena: got %b expected 0", pipe_enq__ENA); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
`ifdef LPM_DESER_ERRCNT_EN
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_err: got %h expected 0", err_count); end
`endif
    nRST = 1'b0;
    exp_err = 0;
    idle_cycles(1);
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b expected 1", in_rdy); end
  endtask

  task automatic test_enter();
    int base;
    base = ena_cnt;
    pipe_enq__RDY = 1'b1;
    applyStimulus(32'h0000_0001);
    applyStimulus(32'hDEAD_BEEF);
    n_checks++; if (pipe_enq__ENA !== 1'b1) begin n_fail++; $display("[TB] FAIL enter_ena: got %b expected 1", pipe_enq__ENA); end
    n_checks++; if (pipe_enq_v !== {16'd0, 32'hDEADBEEF, 96'd0}) begin n_fail++; $display("[TB] FAIL enter_v: got %h expected %h", pipe_enq_v, {16'd0, 32'hDEADBEEF, 96'd0}); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL enter_hold_rdy: got %b expected 0", in_rdy); end
    idle_cycles(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL enter_busy: got %b expected 0", busy); end
    n_checks++; if (ena_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL enter_count: got %0d expected 1", ena_cnt - base); end
  endtask

  task automatic test_write_hold();
    int base;
    logic [143:0] exp_v;
    exp_v = {16'd1, 32'h10, 32'h12345678, 64'd0};
    base = ena_cnt;
    pipe_enq__RDY = 1'b0;
    applyStimulus(32'h0001_0002);
    applyStimulus(32'h0000_0010);
    applyStimulus(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (pipe_enq_v !== exp_v) begin n_fail++; $display("[TB] FAIL write_hold_v[%0d]: got %h expected %h", i, pipe_enq_v, exp_v); end
      n_checks++; if (in_rdy !== 1'b0 || pipe_enq__ENA !== 1'b0) begin n_fail++; $display("[TB] FAIL write_hold_hs[%0d]: got rdy=%b ena=%b expected rdy=0 ena=0", i, in_rdy, pipe_enq__ENA); end
      if (i < 4) idle_cycles(1);
    end
    pipe_enq__RDY = 1'b1;
    #1;
    n_checks++; if (pipe_enq__ENA !== 1'b1) begin n_fail++; $display("[TB] FAIL write_ena: got %b expected 1", pipe_enq__ENA); end
    idle_cycles(1);
    n_checks++; if (ena_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL write_count: got %0d expected 1", ena_cnt - base); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL write_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bad_tag();
    int base;
    base = ena_cnt;
    pipe_enq__RDY = 1'b1;
    applyStimulus(32'h0005_0003);
    exp_err++;
    n_checks++; if (busy !== 1'b1 || in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL badtag_drain: got busy=%b rdy=%b expected 1 1", busy, in_rdy); end
    applyStimulus(32'h0000_0001);
    applyStimulus(32'h1111_1111);
    applyStimulus(32'h2222_2222);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL badtag_idle: got %b expected 0", busy); end
`ifdef LPM_DESER_ERRCNT_EN
    n_checks++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("[TB] FAIL badtag_err: got %0d expected %0d", err_count, exp_err); end
`endif
    applyStimulus(32'h0000_0001);
    applyStimulus(32'hA5A5_0F0F);
    n_checks++; if (pipe_enq_v !== {16'd0, 32'hA5A50F0F, 96'd0} || pipe_enq__ENA !== 1'b1) begin n_fail++; $display("[TB] FAIL badtag_enter: got ena=%b v=%h expected ena=1 v=%h", pipe_enq__ENA, pipe_enq_v, {16'd0, 32'hA5A50F0F, 96'd0}); end
    idle_cycles(1);
    n_checks++; if (ena_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL badtag_count: got %0d expected 1", ena_cnt - base); end
  endtask

  task automatic test_length_errors();
    int base;
    base = ena_cnt;
    pipe_enq__RDY = 1'b1;
    applyStimulus(32'h0000_0002);
    exp_err++;
    applyStimulus(32'h0000_00AA);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL len2_mid: got %b expected 1", busy); end
    applyStimulus(32'h0000_00BB);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL len2_done: got %b expected 0", busy); end
    applyStimulus(32'h0001_0000);
    exp_err++;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_len: got %b expected 0", busy); end
    applyStimulus(32'h0001_0001);
    exp_err++;
    applyStimulus(32'h0000_0033);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL write_len1: got %b expected 0", busy); end
    applyStimulus(32'h0007_0000);
    exp_err++;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL badtag_zero: got %b expected 0", busy); end
    idle_cycles(1);
    n_checks++; if (ena_cnt - base !== 0) begin n_fail++; $display("[TB] FAIL len_count: got %0d expected 0", ena_cnt - base); end
`ifdef LPM_DESER_ERRCNT_EN
    n_checks++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("[TB] FAIL len_err: got %0d expected %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_gaps();
    int base;
    base = ena_cnt;
    pipe_enq__RDY = 1'b1;
    applyStimulus(32'h0001_0002);
    idle_cycles(1);
    n_checks++; if (busy !== 1'b1 || in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_collect: got busy=%b rdy=%b expected 1 1", busy, in_rdy); end
    applyStimulus(32'h0000_0010);
    idle_cycles(2);
    applyStimulus(32'h1234_5678);
    n_checks++; if (pipe_enq_v !== {16'd1, 32'h10, 32'h12345678, 64'd0} || pipe_enq__ENA !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_msg: got ena=%b v=%h expected ena=1 v=%h", pipe_enq__ENA, pipe_enq_v, {16'd1, 32'h10, 32'h12345678, 64'd0}); end
    idle_cycles(1);
    applyStimulus(32'h0000_0003);
    exp_err++;
    applyStimulus(32'h0000_0001);
    idle_cycles(3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_drain: got %b expected 1", busy); end
    applyStimulus(32'h0000_0002);
    applyStimulus(32'h0000_0003);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_drain_done: got %b expected 0", busy); end
    n_checks++; if (ena_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL gap_count: got %0d expected 1", ena_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = ena_cnt;
    pipe_enq__RDY = 1'b1;
    applyStimulus(32'h0001_0002);
    applyStimulus(32'h0000_0010);
    nRST = 1'b1;
    idle_cycles(1);
    nRST = 1'b0;
    exp_err = 0;
    n_checks++; if (busy !== 1'b0 || pipe_enq_v !== 144'd0) begin n_fail++; $display("[TB] FAIL rstmid_state: got busy=%b v=%h expected busy=0 v=0", busy, pipe_enq_v); end
    applyStimulus(32'h0000_0001);
    applyStimulus(32'hCAFE_F00D);
    n_checks++; if (pipe_enq_v !== {16'd0, 32'hCAFEF00D, 96'd0} || pipe_enq__ENA !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_enter: got ena=%b v=%h expected ena=1 v=%h", pipe_enq__ENA, pipe_enq_v, {16'd0, 32'hCAFEF00D, 96'd0}); end
    idle_cycles(1);
    n_checks++; if (ena_cnt - base !== 1) begin n_fail++; $display("[TB] FAIL rstmid_count: got %0d expected 1", ena_cnt - base); end
    base = ena_cnt;
    pipe_enq__RDY = 1'b0;
    applyStimulus(32'h0000_0001);
    applyStimulus(32'h7777_7777);
    nRST = 1'b1;
    idle_cycles(1);
    nRST = 1'b0;
    pipe_enq__RDY = 1'b1;
    idle_cycles(2);
    n_checks++; if (ena_cnt - base !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rsthold: got ena_count=%0d busy=%b expected 0 0", ena_cnt - base, busy); end
`ifdef LPM_DESER_ERRCNT_EN
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_err_clear: got %0d expected 0", err_count); end
`endif
  endtask

`ifdef LPM_DESER_ERRCNT_EN
  task automatic test_saturation();
    in_data  = 32'h0007_0000;
    in_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (err_count !== 16'd3) begin n_fail++; $display("[TB] FAIL sat_early: got %0d expected 3", err_count); end
    repeat (65532) @(posedge CLK);
    #1;
    n_checks++; if (err_count !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_reach: got %h expected FFFF", err_count); end
    repeat (2) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    n_checks++; if (err_count !== 16'hFFFF || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_hold: got err=%h busy=%b expected FFFF 0", err_count, busy); end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_enter();
    test_write_hold();
    test_bad_tag();
    test_length_errors();
    test_gaps();
    test_reset_mid();
`ifdef LPM_DESER_ERRCNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
